fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter sequencer and access arbiter for the byte-addressed, big-endian LEGv8 instruction memory (4 bytes per instruction, MSB at lowest address).
- Owns the PC.
- Drives the memory read address and registers the returned 32-bit instruction for decode.
- Applies stall and branch redirects from downstream.
- Grants the memory write port to a byte-wide program loader, which has priority over fetch.

Parameters:
RESET_PC, 0, byte address fetched first after reset and after every load session
MEM_BYTES, 64, instruction memory size in bytes; multiple of 4
ADDR_W, 6, loader byte-address width; 2**ADDR_W >= MEM_BYTES

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold fetch state this cycle
branchTaken  in  1  redirect PC relative to fetchPC
branchOffset  in  26  signed word offset (B-format imm26)
imemAddr  out  64  read address to instruction memory (= pc)
imemInstr  in  32  combinational read data for imemAddr
instruction  out  32  registered instruction to decode
fetchPC  out  64  byte address of instruction
instrValid  out  1  instruction/fetchPC valid
halted  out  1  PC left memory range
loadReq  in  1  loader requests memory ownership
loadValid  in  1  loader byte strobe
loadAddr  in  ADDR_W  loader byte address
loadData  in  8  loader byte
loadBusy  out  1  loader owns memory
imemWrEn  out  1  byte write enable to instruction memory
imemWrAddr  out  ADDR_W  byte write address
imemWrData  out  8  byte write data
fetchCount  out  32  delivered-instruction count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- States: FETCH, LOAD, HALT. Next-state priority: loadReq > out-of-range > branchTaken > stall > advance.
- Reset values: state = FETCH; pc = RESET_PC; instruction = 0; fetchPC = 0; instrValid = 0; halted = 0; loadBusy = 0; imemWrEn = 0; fetchCount = 0. Reset asserted mid-operation aborts any fetch or load immediately, and a loader write in that cycle is dropped.
- imemAddr = pc, continuously, in every state.

FETCH behaviour:
- Advance: on each edge with no higher-priority event:
  - instruction <= imemInstr, fetchPC <= pc, instrValid <= 1.
  - pc <= pc + 4, 64-bit wrap.
  - Latency: one cycle from pc to instruction.
- stall = 1: pc, instruction, fetchPC and instrValid hold their values.
- branchTaken = 1 (overrides stall):
  - pc <= fetchPC + (sign_extend_64(branchOffset) << 2).
  - instrValid <= 0 for one cycle, squashing the sequentially fetched word.
  - branchTaken while instrValid = 0 is ignored.
- Out of range: if pc > MEM_BYTES - 4 or pc[1:0] != 0 at an edge:
  - state <= HALT, instrValid <= 0, halted <= 1.
  - This check applies to the current pc; a branch target is checked on the following edge.

HALT behaviour:
- pc and outputs frozen; halted = 1.
- Exited only by rst_n or loadReq.

LOAD behaviour:
- Entry: loadReq = 1 in any state → state <= LOAD, loadBusy <= 1, instrValid <= 0, halted <= 0.
- The instruction in flight at entry is discarded.
- In LOAD:
  - imemWrEn = loadValid, combinational.
  - imemWrAddr = loadAddr, imemWrData = loadData.
  - Writes with loadAddr >= MEM_BYTES are suppressed (imemWrEn = 0).
  - Fetch is frozen.
- Writes are never issued outside LOAD.
- Exit: loadReq = 0 in LOAD → state <= FETCH, loadBusy <= 0, pc <= RESET_PC. The first valid instruction appears two edges after loadReq falls.
- loadValid while loadReq = 0 is ignored.

Optional Feature:
FETCH_COUNT_EN
- Defined: fetchCount increments by 1 on every edge where instrValid becomes or remains 1 due to an advance (not stall-hold). Wraps at 2**32. Clears on reset; holds through LOAD and HALT.
- Undefined: fetchCount is tied to 0 and no counter logic is generated.

Test Plan:
- Sequential fetch: memory preloaded with words 0xF842802A, 0xCB03804B; release reset → instruction = 0xF842802A with fetchPC = 0 after edge 1, then 0xCB03804B with fetchPC = 4 after edge 2, instrValid = 1.
- Stall: stall high for 3 cycles at fetchPC = 4 → instruction, fetchPC and imemAddr = 8 unchanged for 3 cycles; resumes with fetchPC = 8.
- Branch: fetchPC = 8, branchTaken with offset = 26'h3FFFFFE (−2) → pc = 0; instrValid = 0 for one cycle, then fetchPC = 0. Also: branchTaken together with stall → branch wins.
- End of memory: MEM_BYTES = 64, sequential run → after fetchPC = 60 is delivered, halted = 1, instrValid = 0, pc frozen at 64.
- Loader: in HALT, assert loadReq and write bytes 0x8B,0x03,0x00,0x8C at addresses 0..3, plus one write at address 64 → exactly 4 imemWrEn pulses (address-64 write suppressed); drop loadReq → halted = 0 and instruction = 0x8B03008C, fetchPC = 0, two edges later.
- Reset mid-load: rst_n low during a loadValid cycle → imemWrEn = 0 and loadBusy = 0 immediately; after release, fetch restarts from RESET_PC. With FETCH_COUNT_EN defined, fetchCount returns to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// PC sequencer and instruction-memory arbiter for a big-endian LEGv8 fetch stage.
// Optional build macro FETCH_COUNT_EN enables the delivered-instruction counter.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 64,
    parameter int          ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [25:0]       branchOffset,
    output logic [63:0]       imemAddr,
    input  logic [31:0]       imemInstr,
    output logic [31:0]       instruction,
    output logic [63:0]       fetchPC,
    output logic              instrValid,
    output logic              halted,
    input  logic              loadReq,
    input  logic              loadValid,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [7:0]        loadData,
    output logic              loadBusy,
    output logic              imemWrEn,
    output logic [ADDR_W-1:0] imemWrAddr,
    output logic [7:0]        imemWrData,
    output logic [31:0]       fetchCount
);

    typedef enum logic [1:0] {FETCH, LOAD, HALT} state_t;

    localparam logic [63:0] LAST_PC   = 64'(MEM_BYTES - 4);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state, stateNext;
    logic [63:0] pc, pcNext, fetchPCNext, branchTarget;
    logic [31:0] instrNext;
    logic        validNext, haltedNext, busyNext;
    logic        outOfRange, branchHit, advance;

    assign imemAddr     = pc;
    assign outOfRange   = (pc > LAST_PC) || (pc[1:0] != 2'b00);
    assign branchTarget = fetchPC + {{36{branchOffset[25]}}, branchOffset, 2'b00};
    // A branch is only meaningful relative to a valid delivered instruction.
    assign branchHit    = branchTaken && instrValid;
    assign advance      = (state == FETCH) && !loadReq && !outOfRange && !branchHit && !stall;

    // Writes are steered straight from the loader; only LOAD with loadReq held may commit one.
    assign imemWrEn   = (state == LOAD) && loadReq && loadValid && (32'(loadAddr) < MEM_LIMIT);
    assign imemWrAddr = loadAddr;
    assign imemWrData = loadData;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateNext   = state;
        pcNext      = pc;
        instrNext   = instruction;
        fetchPCNext = fetchPC;
        validNext   = instrValid;
        haltedNext  = halted;
        busyNext    = loadBusy;
        if (loadReq) begin
            stateNext  = LOAD;
            busyNext   = 1'b1;
            validNext  = 1'b0;
            haltedNext = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (outOfRange) begin
                        stateNext  = HALT;
                        validNext  = 1'b0;
                        haltedNext = 1'b1;
                    end else if (branchHit) begin
                        pcNext    = branchTarget;
                        validNext = 1'b0;
                    end else if (advance) begin
                        instrNext   = imemInstr;
                        fetchPCNext = pc;
                        validNext   = 1'b1;
                        pcNext      = pc + 64'd4;
                    end
                end
                LOAD: begin
                    stateNext = FETCH;
                    busyNext  = 1'b0;
                    pcNext    = RESET_PC;
                end
                HALT:    ;
                default: stateNext = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instruction <= 32'd0;
            fetchPC     <= 64'd0;
            instrValid  <= 1'b0;
            halted      <= 1'b0;
            loadBusy    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state       <= stateNext;
            pc          <= pcNext;
            instruction <= instrNext;
            fetchPC     <= fetchPCNext;
            instrValid  <= validNext;
            halted      <= haltedNext;
            loadBusy    <= busyNext;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] countReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       countReg <= 32'd0;
        else if (advance) countReg <= countReg + 32'd1;
    end

    assign fetchCount = countReg;
`else
    assign fetchCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a byte-wide big-endian memory model.
module tb_fetch_sequencer;

    localparam int MEM_BYTES = 64;
    localparam int ADDR_W    = 7;
`ifdef FETCH_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              branchTaken;
    logic [25:0]       branchOffset;
    logic [63:0]       imemAddr;
    logic [31:0]       imemInstr;
    logic [31:0]       instruction;
    logic [63:0]       fetchPC;
    logic              instrValid;
    logic              halted;
    logic              loadReq;
    logic              loadValid;
    logic [ADDR_W-1:0] loadAddr;
    logic [7:0]        loadData;
    logic              loadBusy;
    logic              imemWrEn;
    logic [ADDR_W-1:0] imemWrAddr;
    logic [7:0]        imemWrData;
    logic [31:0]       fetchCount;

    logic [7:0] mem [0:63];
    logic       preload;
    int         nChecks = 0;
    int         nFail   = 0;
    int         pulses  = 0;

    fetch_sequencer #(
        .RESET_PC (64'd0),
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .branchTaken (branchTaken),
        .branchOffset(branchOffset),
        .imemAddr    (imemAddr),
        .imemInstr   (imemInstr),
        .instruction (instruction),
        .fetchPC     (fetchPC),
        .instrValid  (instrValid),
        .halted      (halted),
        .loadReq     (loadReq),
        .loadValid   (loadValid),
        .loadAddr    (loadAddr),
        .loadData    (loadData),
        .loadBusy    (loadBusy),
        .imemWrEn    (imemWrEn),
        .imemWrAddr  (imemWrAddr),
        .imemWrData  (imemWrData),
        .fetchCount  (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int w);
        case (w)
            0:       return 32'hF842802A;
            1:       return 32'hCB03804B;
            default: return 32'h1000_0000 + 32'(w);
        endcase
    endfunction

    function automatic logic [31:0] expCount(input int n);
        return COUNT_EN ? 32'(n) : 32'd0;
    endfunction

    // Memory model: preload while held in reset, then accept loader byte writes.
    always @(posedge clk) begin
        if (preload) begin
            for (int w = 0; w < 16; w++) begin
                automatic logic [31:0] wd = initWord(w);
                mem[4*w]   <= wd[31:24];
                mem[4*w+1] <= wd[23:16];
                mem[4*w+2] <= wd[15:8];
                mem[4*w+3] <= wd[7:0];
            end
        end else if (imemWrEn && imemWrAddr < 7'd64) begin
            mem[imemWrAddr[5:0]] <= imemWrData;
        end
    end

    always_comb begin
        imemInstr = 32'h0;
        if (imemAddr <= 64'd60)
            imemInstr = {mem[imemAddr[5:0]], mem[imemAddr[5:0] + 6'd1],
                         mem[imemAddr[5:0] + 6'd2], mem[imemAddr[5:0] + 6'd3]};
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadByte(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic expEn);
        loadValid = 1'b1;
        loadAddr  = a;
        loadData  = d;
        #1;
        check("load_wren", imemWrEn, expEn);
        if (imemWrEn) pulses++;
        step();
        loadValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; preload = 1'b1;
        stall = 1'b0; branchTaken = 1'b0; branchOffset = '0;
        loadReq = 1'b0; loadValid = 1'b0; loadAddr = '0; loadData = '0;
        #2;
        check("rst_valid",   instrValid,  0);
        check("rst_halted",  halted,      0);
        check("rst_busy",    loadBusy,    0);
        check("rst_wren",    imemWrEn,    0);
        check("rst_instr",   instruction, 0);
        check("rst_fetchpc", fetchPC,     0);
        check("rst_pc",      imemAddr,    0);
        check("rst_count",   fetchCount,  0);
        @(posedge clk); @(posedge clk); #1 preload = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Sequential fetch
        step();
        check("seq1_instr", instruction, 32'hF842802A);
        check("seq1_pc",    fetchPC,     0);
        check("seq1_valid", instrValid,  1);
        step();
        check("seq2_instr", instruction, 32'hCB03804B);
        check("seq2_pc",    fetchPC,     4);
        check("seq2_addr",  imemAddr,    8);

        // Stall for three edges
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", instruction, 32'hCB03804B);
            check("stall_pc",    fetchPC,     4);
            check("stall_addr",  imemAddr,    8);
            check("stall_valid", instrValid,  1);
        end
        stall = 1'b0;
        step();
        check("resume_pc",    fetchPC,     8);
        check("resume_instr", instruction, 32'h1000_0002);
        check("resume_count", fetchCount,  expCount(3));

        // Backward branch by -2 words from fetchPC 8
        branchTaken = 1'b1; branchOffset = 26'h3FFFFFE;
        step();
        branchTaken = 1'b0;
        check("br_valid", instrValid, 0);
        check("br_addr",  imemAddr,   0);
        step();
        check("br_fetchpc", fetchPC,     0);
        check("br_instr",   instruction, 32'hF842802A);
        check("br_valid2",  instrValid,  1);

        // Branch beats stall; a branch on an invalid slot is ignored
        branchTaken = 1'b1; stall = 1'b1; branchOffset = 26'd3;
        step();
        check("brst_valid", instrValid, 0);
        check("brst_addr",  imemAddr,   12);
        stall = 1'b0; branchOffset = 26'd5;
        step();
        branchTaken = 1'b0;
        check("brign_fetchpc", fetchPC,    12);
        check("brign_valid",   instrValid, 1);
        check("brign_addr",    imemAddr,   16);

        // Run off the end of memory
        for (int i = 0; i < 12; i++) step();
        check("end_fetchpc", fetchPC,     60);
        check("end_instr",   instruction, 32'h1000_000F);
        check("end_addr",    imemAddr,    64);
        check("end_count",   fetchCount,  expCount(17));
        step();
        check("halt_flag",  halted,     1);
        check("halt_valid", instrValid, 0);
        check("halt_addr",  imemAddr,   64);
        step();
        check("halt_hold_addr", imemAddr, 64);
        check("halt_hold_pc",   fetchPC,  60);
        check("halt_count",     fetchCount, expCount(17));

        // Loader session from HALT
        loadReq = 1'b1;
        step();
        check("load_busy",   loadBusy,   1);
        check("load_halted", halted,     0);
        check("load_valid",  instrValid, 0);
        pulses = 0;
        loadByte(7'd0,  8'h8B, 1'b1);
        loadByte(7'd1,  8'h03, 1'b1);
        loadByte(7'd2,  8'h00, 1'b1);
        loadByte(7'd3,  8'h8C, 1'b1);
        loadByte(7'd64, 8'hEE, 1'b0);
        check("load_pulses", 32'(pulses), 4);
        loadReq = 1'b0;
        step();
        check("exit_busy",  loadBusy,   0);
        check("exit_valid", instrValid, 0);
        check("exit_addr",  imemAddr,   0);
        loadValid = 1'b1; loadAddr = 7'd8; loadData = 8'h55;
        #1;
        check("idle_wren", imemWrEn, 0);
        step();
        loadValid = 1'b0;
        check("exit_instr",   instruction, 32'h8B03008C);
        check("exit_fetchpc", fetchPC,     0);
        check("exit_valid2",  instrValid,  1);
        check("exit_halted",  halted,      0);
        check("exit_count",   fetchCount,  expCount(18));

        // Reset in the middle of a loader write
        loadReq = 1'b1;
        step();
        loadValid = 1'b1; loadAddr = 7'd4; loadData = 8'hFF;
        #1;
        check("mid_wren_pre", imemWrEn, 1);
        rst_n = 1'b0;
        #1;
        check("mid_wren",  imemWrEn,   0);
        check("mid_busy",  loadBusy,   0);
        check("mid_valid", instrValid, 0);
        check("mid_count", fetchCount, 0);
        loadReq = 1'b0; loadValid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rest_fetchpc", fetchPC,     0);
        check("rest_instr",   instruction, 32'h8B03008C);
        step();
        check("rest_fetchpc2", fetchPC,     4);
        check("rest_instr2",   instruction, 32'hCB03804B);
        check("rest_count",    fetchCount,  expCount(2));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
